// File: rtl/uart_recv_if.sv
// ============================================================
// uart_recv_if : serial line and received-byte signals of uart_recv
// Rev 1.0
// ============================================================
`default_nettype none

interface uart_recv_if;
   logic       uart_rxd;
   logic       uart_done;
   logic [7:0] uart_data;
   logic       frame_err;

   modport master (
      output uart_rxd,
      input  uart_done,
      input  uart_data,
      input  frame_err
   );

   modport slave (
      input  uart_rxd,
      output uart_done,
      output uart_data,
      output frame_err
   );
endinterface

`default_nettype wire

// File: rtl/uart_recv.sv
// ============================================================
// uart_recv : 8N1 UART receiver, bit timing counted in sys_clk cycles
// Option    : `define UART_RX_MAJORITY_EN for 2-of-3 sampling per bit
// Rev 1.0
// ============================================================
`default_nettype none

module uart_recv #(
   parameter int CLK_FREQ = 50000000,
   parameter int UART_BPS = 115200
) (
   input  wire logic  sys_clk,
   input  wire logic  sys_rst_n,
   uart_recv_if.slave rx
);
   localparam int          BPS_CNT  = CLK_FREQ / UART_BPS;
   localparam logic [15:0] C_LAST   = 16'(BPS_CNT - 1);
   localparam logic [15:0] C_SAMPLE = 16'(BPS_CNT / 2);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [15:0] C_PRE    = 16'(BPS_CNT / 2 - 1);
   localparam logic [15:0] C_DECIDE = 16'(BPS_CNT / 2 + 1);
`else
   localparam logic [15:0] C_DECIDE = C_SAMPLE;
`endif
   localparam logic [0:0]  S_IDLE   = 1'b0;
   localparam logic [0:0]  S_RECV   = 1'b1;

   logic        rxd_d0_q, rxd_d1_q, rxd_d2_q;
   logic [0:0]  state_q, state_d;
   logic [15:0] clk_cnt_q, clk_cnt_d;
   logic [3:0]  rx_cnt_q, rx_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        start_edge_w;
   logic        decide_w;
   logic        bit_w;

   assign start_edge_w = rxd_d2_q & ~rxd_d1_q;
   assign decide_w     = (state_q == S_RECV) && (clk_cnt_q == C_DECIDE);

`ifdef UART_RX_MAJORITY_EN
   logic [1:0]  vote_q, vote_d;

   assign bit_w = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_d1_q) | (vote_q[1] & rxd_d1_q);

   always_comb begin
      vote_d = vote_q;
      if (state_q == S_RECV) begin
         if (clk_cnt_q == C_PRE)
            vote_d[0] = rxd_d1_q;
         if (clk_cnt_q == C_SAMPLE)
            vote_d[1] = rxd_d1_q;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
         vote_q <= 2'b00;
      else
         vote_q <= vote_d;
   end
`else
   assign bit_w = rxd_d1_q;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rxd_d0_q  <= 1'b1;
         rxd_d1_q  <= 1'b1;
         rxd_d2_q  <= 1'b1;
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         rx_cnt_q  <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         rxd_d0_q  <= rx.uart_rxd;
         rxd_d1_q  <= rxd_d0_q;
         rxd_d2_q  <= rxd_d1_q;
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         rx_cnt_q  <= rx_cnt_d;
         shift_q   <= shift_d;
         data_q    <= data_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   // Leaving RECV at the stop-bit decision point lets a back-to-back start edge be caught.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_edge_w) state_d = S_RECV;
         S_RECV:  if (decide_w && (((rx_cnt_q == 4'd0) && bit_w) || (rx_cnt_q == 4'd9)))
                     state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      clk_cnt_d = clk_cnt_q;
      rx_cnt_d  = rx_cnt_q;
      shift_d   = shift_q;
      data_d    = data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      if (state_q == S_IDLE) begin
         clk_cnt_d = '0;
         rx_cnt_d  = '0;
      end else begin
         if (clk_cnt_q == C_LAST) begin
            clk_cnt_d = '0;
            rx_cnt_d  = rx_cnt_q + 4'd1;
         end else begin
            clk_cnt_d = clk_cnt_q + 16'd1;
         end
         if (decide_w) begin
            if ((rx_cnt_q >= 4'd1) && (rx_cnt_q <= 4'd8))
               shift_d[3'(rx_cnt_q - 4'd1)] = bit_w;
            if (rx_cnt_q == 4'd9) begin
               if (bit_w) begin
                  data_d = shift_q;
                  done_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
               end
            end
         end
      end
   end

   assign rx.uart_done = done_q;
   assign rx.uart_data = data_q;
   assign rx.frame_err = err_q;

endmodule

`default_nettype wire

// File: doc/uart_recv.md
Name: uart_recv

Overview:
- Asynchronous serial receiver; the downstream partner of the uart_send transmitter.
- Accepts the 8N1 line (1 start, 8 data LSB-first, 1 stop, no parity) and returns the byte as parallel data with a 1-cycle done strobe.
- Sits between the board RXD pin (or a uart_send txd in loopback) and the byte consumer / loopback logic.
- Bit timing is derived by counting sys_clk cycles; there is no oversampling clock.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate in bit/s.
- BPS_CNT, CLK_FREQ/UART_BPS, sys_clk cycles per bit (434 at defaults). Integer division, truncated. Must be ≥ 8.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge.
- sys_rst_n  input  1  asynchronous active-low reset.
- uart_rxd  input  1  serial line, asynchronous to sys_clk, idle high.
- uart_done  output  1  1-cycle pulse: uart_data holds a newly received valid byte.
- uart_data  output  8  last valid received byte; held until the next valid frame.
- frame_err  output  1  1-cycle pulse: stop bit sampled low; byte discarded.

Behaviour:
- Reset values:
  - uart_done=0, uart_data=8'h00, frame_err=0.
  - Internal: rx_flag=0, clk_cnt=0, rx_cnt=0, shift register=0.
  - Synchronizer stages rxd_d0=rxd_d1=1; a third stage, rxd_d2, also resets to 1.
- Input sync:
  - uart_rxd passes through a 2-FF synchronizer (rxd_d0→rxd_d1), then one more register, rxd_d2.
  - start_edge = rxd_d2 & ~rxd_d1. Only this synchronized value is used downstream.
- States: IDLE (rx_flag=0) and RECV (rx_flag=1).
- IDLE → RECV:
  - On start_edge, set rx_flag and clear clk_cnt and rx_cnt.
  - start_edge is ignored while in RECV.
- Counting in RECV:
  - clk_cnt counts 0..BPS_CNT-1 (16-bit), then wraps to 0 and increments rx_cnt (4-bit).
  - rx_cnt 0 = start bit, 1..8 = data[0..7], 9 = stop bit.
- Sample point: the cycle where clk_cnt == BPS_CNT/2 (SAMPLE). The bit value is rxd_d1.
- Start validation: at SAMPLE with rx_cnt==0, if the bit is 1 (glitch), return to IDLE. No pulse is raised and uart_data is unchanged.
- Data bits: at SAMPLE with rx_cnt==1..8, store the bit into shift register position rx_cnt-1.
- Stop bit: at SAMPLE with rx_cnt==9:
  - Bit 1: on that edge, uart_data takes the shift register and uart_done=1.
  - Bit 0: frame_err=1 and uart_data is unchanged.
  - Either way, rx_flag clears on the same edge (back to IDLE at mid-stop-bit), so a back-to-back start edge is caught.
- Pulses: uart_done and frame_err are high for exactly 1 cycle and are never high together.
- Latency: uart_done rises between 9*BPS_CNT+BPS_CNT/2+2 and +4 sys_clk cycles after the falling edge of the start bit on uart_rxd.
- Reset mid-frame: all state returns to reset values immediately, and the partial byte is lost.
- Line held low at reset release:
  - The synchronizer resets high, so this is treated as a start edge.
  - It ends in frame_err (stop sampled low). This is required behaviour.
- Line held low (break): after a frame_err, no further activity until the line returns high and a new falling edge occurs.
- Baud tolerance: must receive correctly with up to ±2% rate mismatch at defaults.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit is sampled at clk_cnt == BPS_CNT/2-1, BPS_CNT/2 and BPS_CNT/2+1.
  - The bit value is the 2-of-3 majority, decided at BPS_CNT/2+1.
  - Start validation, data capture, stop check and the return to IDLE all occur at BPS_CNT/2+1. The latency window therefore shifts by +1 cycle.
  - A single-cycle glitch inside the sample window is rejected.
- Undefined: single sample at BPS_CNT/2 exactly as described above.

Test Plan:
- Loopback: uart_send (same parameters) txd→uart_rxd, send 8'hA5 → one uart_done pulse, uart_data=8'hA5, frame_err stays 0, latency inside the window above.
- Back-to-back: send 8'h00, 8'hFF, 8'h55 with no idle gap → three uart_done pulses, uart_data 00, FF, 55 in order, no frame_err.
- False start: drive uart_rxd low for 100 cycles (< BPS_CNT/2=217), then high → no uart_done, no frame_err, uart_data unchanged, next frame 8'h3C received correctly.
- Framing error: drive start, data 8'h81, then stop bit low for one bit time, then high → frame_err pulse at stop SAMPLE, no uart_done, uart_data keeps its previous value 8'h3C.
- Reset mid-frame: assert sys_rst_n low during data bit 4 of 8'hC3, release while the line is idle high, then send 8'h7E → no pulse for the aborted byte, uart_data=8'h00 after reset, then 8'h7E with uart_done.
- Majority (UART_RX_MAJORITY_EN defined): inject a 1-cycle inverted glitch at clk_cnt==BPS_CNT/2 on data bit 2 of 8'h5A → uart_data=8'h5A. Without the macro, the same stimulus gives 8'h5E.
